// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_tx_arbiter                                               |
// | Brief    : Round-robin arbiter sharing one UART transmit path among      |
// |            NUM_REQ requesters, with busy-start timeout detection.        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module uart_tx_arbiter #(
  parameter int BIT_WIDTH    = 8,
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*BIT_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           done,
  output logic [NUM_REQ-1:0]           err,
  output logic                         uart_send,
  input  logic                         uart_busy,
  output logic [BIT_WIDTH-1:0]         uart_tx_reg,
  output logic                         active
);

  localparam int c_idx_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int c_tmr_w = $clog2(BUSY_TIMEOUT);
  localparam logic [c_idx_w-1:0] c_last_rst    = c_idx_w'(NUM_REQ - 1);
  localparam logic [c_tmr_w-1:0] c_timeout_end = c_tmr_w'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [NUM_REQ-1:0]   r_grant, w_grant_nxt;
  logic [NUM_REQ-1:0]   r_done, w_done_nxt;
  logic [NUM_REQ-1:0]   r_err, w_err_nxt;
  logic                 r_send, w_send_nxt;
  logic [BIT_WIDTH-1:0] r_tx, w_tx_nxt;
  logic                 r_active, w_active_nxt;
  logic [c_idx_w-1:0]   r_last, w_last_nxt;
  logic [c_idx_w-1:0]   r_owner, w_owner_nxt;
  logic [c_tmr_w-1:0]   r_timer, w_timer_nxt;

  logic [BIT_WIDTH-1:0] w_words [NUM_REQ];
  logic                 w_found;
  logic [c_idx_w-1:0]   w_sel;
  int                   w_cand;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_words[gi] = req_data[gi*BIT_WIDTH +: BIT_WIDTH];
    end
  endgenerate

  // Rotating search: start just after the last served requester and wrap.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_cand  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = int'(r_last) + k;
      if (w_cand >= NUM_REQ) w_cand = w_cand - NUM_REQ;
      if (!w_found && req[c_idx_w'(w_cand)]) begin
        w_found = 1'b1;
        w_sel   = c_idx_w'(w_cand);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = '0;
    w_done_nxt  = '0;
    w_err_nxt   = '0;
    w_send_nxt  = 1'b0;
    w_tx_nxt    = r_tx;
    w_last_nxt  = r_last;
    w_owner_nxt = r_owner;
    w_timer_nxt = r_timer;
    case (r_state)
      IDLE: begin
        if (w_found && !uart_busy) begin
          w_grant_nxt[w_sel] = 1'b1;
          w_tx_nxt           = w_words[w_sel];
          w_send_nxt         = 1'b1;
          w_last_nxt         = w_sel;
          w_owner_nxt        = w_sel;
          w_timer_nxt        = '0;
          w_state_nxt        = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (uart_busy) begin
          w_state_nxt = WAIT_DONE;
        end else if (r_timer == c_timeout_end) begin
          w_err_nxt[r_owner] = 1'b1;
          w_state_nxt        = IDLE;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!uart_busy) begin
          w_done_nxt[r_owner] = 1'b1;
          w_state_nxt         = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_active_nxt = (w_state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_done   <= '0;
      r_err    <= '0;
      r_send   <= 1'b0;
      r_tx     <= '0;
      r_active <= 1'b0;
      r_last   <= c_last_rst;
      r_owner  <= '0;
      r_timer  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
      r_send   <= w_send_nxt;
      r_tx     <= w_tx_nxt;
      r_active <= w_active_nxt;
      r_last   <= w_last_nxt;
      r_owner  <= w_owner_nxt;
      r_timer  <= w_timer_nxt;
    end
  end

  assign grant       = r_grant;
  assign done        = r_done;
  assign err         = r_err;
  assign uart_send   = r_send;
  assign uart_tx_reg = r_tx;
  assign active      = r_active;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_uart_tx_arbiter                                            |
// | Brief    : Directed self-checking bench for uart_tx_arbiter.             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_uart_tx_arbiter;

  localparam int c_bw = 8;
  localparam int c_n  = 4;
  localparam int c_to = 16;

  logic              clk;
  logic              rst;
  logic [c_n-1:0]    req;
  logic [c_n*c_bw-1:0] req_data;
  logic [c_n-1:0]    grant, done, err;
  logic              uart_send, uart_busy, active;
  logic [c_bw-1:0]   uart_tx_reg;

  int vectors    = 0;
  int miscompares = 0;

  uart_tx_arbiter #(.BIT_WIDTH(c_bw), .NUM_REQ(c_n), .BUSY_TIMEOUT(c_to)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .grant(grant), .done(done), .err(err), .uart_send(uart_send),
    .uart_busy(uart_busy), .uart_tx_reg(uart_tx_reg), .active(active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n clock edges; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_outs(input string tag, input logic [3:0] g, input logic [3:0] d,
                          input logic [3:0] e, input logic s, input logic a);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".done"}, 32'(done), 32'(d));
    chk({tag, ".err"}, 32'(err), 32'(e));
    chk({tag, ".send"}, 32'(uart_send), 32'(s));
    chk({tag, ".active"}, 32'(active), 32'(a));
  endtask

  initial begin
    rst = 1'b1; req = '0; req_data = '0; uart_busy = 1'b0;
    cyc(2);
    chk_outs("reset", 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    chk("reset.tx", 32'(uart_tx_reg), 32'h0);
    rst = 1'b0;

    // Single request, busy held for 10 cycles
    req = 4'b0001; req_data = 32'h0000_00A5;
    cyc(1);
    chk_outs("single.grant", 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b1);
    chk("single.tx", 32'(uart_tx_reg), 32'hA5);
    req = 4'b0000; uart_busy = 1'b1;
    cyc(1);
    chk_outs("single.wait", 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
    cyc(9);
    chk_outs("single.busy", 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
    uart_busy = 1'b0;
    cyc(1);
    chk_outs("single.done", 4'b0000, 4'b0001, 4'b0000, 1'b0, 1'b0);
    chk("single.tx_keep", 32'(uart_tx_reg), 32'hA5);
    cyc(1);
    chk_outs("single.idle", 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);

    // All requests held after a fresh reset: order 0,1,2,3,0
    rst = 1'b1; cyc(1); rst = 1'b0;
    req = 4'b1111; req_data = 32'h1312_1110;
    cyc(1);
    chk("rr.g0", 32'(grant), 32'h1);
    chk("rr.tx0", 32'(uart_tx_reg), 32'h10);
    uart_busy = 1'b1; cyc(1);
    chk("rr.g0_off", 32'(grant), 32'h0);
    cyc(1); uart_busy = 1'b0; cyc(1);
    chk("rr.d0", 32'(done), 32'h1);
    chk("rr.g_in_done", 32'(grant), 32'h0);
    cyc(1);
    chk("rr.g1", 32'(grant), 32'h2);
    chk("rr.tx1", 32'(uart_tx_reg), 32'h11);
    uart_busy = 1'b1; cyc(2); uart_busy = 1'b0; cyc(1);
    chk("rr.d1", 32'(done), 32'h2);
    cyc(1);
    chk("rr.g2", 32'(grant), 32'h4);
    chk("rr.tx2", 32'(uart_tx_reg), 32'h12);
    uart_busy = 1'b1; cyc(2); uart_busy = 1'b0; cyc(1);
    chk("rr.d2", 32'(done), 32'h4);
    cyc(1);
    chk("rr.g3", 32'(grant), 32'h8);
    chk("rr.tx3", 32'(uart_tx_reg), 32'h13);
    uart_busy = 1'b1; cyc(2); uart_busy = 1'b0; cyc(1);
    chk("rr.d3", 32'(done), 32'h8);
    cyc(1);
    chk("rr.g0b", 32'(grant), 32'h1);
    chk("rr.tx0b", 32'(uart_tx_reg), 32'h10);
    uart_busy = 1'b1; cyc(2); uart_busy = 1'b0; cyc(1);
    chk("rr.d0b", 32'(done), 32'h1);
    req = 4'b0000;
    cyc(1);
    chk_outs("rr.end", 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);

    // Timeout: busy never rises
    req = 4'b0001; req_data = 32'h0000_005C;
    cyc(1);
    chk_outs("to.grant", 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b1);
    req = 4'b0000;
    cyc(c_to - 1);
    chk_outs("to.before", 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
    cyc(1);
    chk_outs("to.err", 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0);
    req = 4'b0001; req_data = 32'h0000_0077;
    cyc(1);
    chk_outs("to.retry", 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b1);
    chk("to.retry_tx", 32'(uart_tx_reg), 32'h77);
    req = 4'b0000; uart_busy = 1'b1; cyc(1); uart_busy = 1'b0; cyc(1);
    chk_outs("to.done", 4'b0000, 4'b0001, 4'b0000, 1'b0, 1'b0);

    // Busy already high at request
    uart_busy = 1'b1; req = 4'b0100; req_data = 32'h0033_0000;
    cyc(3);
    chk_outs("busy.hold", 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    uart_busy = 1'b0;
    cyc(1);
    chk_outs("busy.grant", 4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b1);
    chk("busy.tx", 32'(uart_tx_reg), 32'h33);
    req = 4'b0000; uart_busy = 1'b1; cyc(1); uart_busy = 1'b0; cyc(1);
    chk("busy.done", 32'(done), 32'h4);

    // Fairness and withdrawal
    req = 4'b0010; req_data = 32'h4433_2211;
    cyc(1);
    chk("fair.g1", 32'(grant), 32'h2);
    req = 4'b0011; uart_busy = 1'b1;
    cyc(1);
    req = 4'b0111;
    cyc(1);
    chk("fair.wd_grant", 32'(grant), 32'h0);
    req = 4'b0011; uart_busy = 1'b0;
    cyc(1);
    chk_outs("fair.d1", 4'b0000, 4'b0010, 4'b0000, 1'b0, 1'b0);
    cyc(1);
    chk_outs("fair.g0", 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b1);
    chk("fair.tx0", 32'(uart_tx_reg), 32'h11);
    req = 4'b0000; uart_busy = 1'b1; cyc(1); uart_busy = 1'b0; cyc(1);
    chk("fair.d0", 32'(done), 32'h1);
    cyc(2);
    chk_outs("fair.quiet", 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);

    // Reset during WAIT_DONE
    req = 4'b0001;
    cyc(1);
    chk("rst.g0", 32'(grant), 32'h1);
    req = 4'b0000; uart_busy = 1'b1;
    cyc(1);
    chk("rst.active", 32'(active), 32'h1);
    rst = 1'b1;
    cyc(1);
    chk_outs("rst.outs", 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    chk("rst.tx", 32'(uart_tx_reg), 32'h0);
    rst = 1'b0; uart_busy = 1'b0;
    cyc(1);
    chk_outs("rst.nodone", 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    req = 4'b1111;
    cyc(1);
    chk_outs("rst.g0", 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b1);
    chk("rst.tx0", 32'(uart_tx_reg), 32'h11);
    req = 4'b0000;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single transmit path of a `uart` instance among `NUM_REQ` requesters. Each requester presents a byte and a request. The arbiter grants one requester at a time, loads its data into the UART `tx_reg`, pulses `send`, and tracks `busy` through to completion. It then reports completion, or an error if the UART never started. It sits directly between the requesting blocks and the `uart` wrapper's `send`/`busy`/`tx_reg` ports.

## Interface
- `BIT_WIDTH`, 8: data word width; must match the UART `BIT_WIDTH`.
- `NUM_REQ`, 4: number of requesters, 2..16.
- `BUSY_TIMEOUT`, 16: cycles to wait for `uart_busy` to rise after `send` before aborting; must be ≥2.

Ports:
- `clk`  in  1  system clock. One clock domain only.
- `rst`  in  1  reset, synchronous and active-high.
- `req`  in  NUM_REQ  per-requester request level.
- `req_data`  in  NUM_REQ*BIT_WIDTH  requester i data is in bits [i*BIT_WIDTH +: BIT_WIDTH].
- `grant`  out  NUM_REQ  one-hot, one-cycle pulse: the requester's data has been latched.
- `done`  out  NUM_REQ  one-hot, one-cycle pulse: the requester's word has finished transmitting.
- `err`  out  NUM_REQ  one-hot, one-cycle pulse: the UART did not go busy within `BUSY_TIMEOUT` cycles.
- `uart_send`  out  1  to UART `send`; one-cycle pulse.
- `uart_busy`  in  1  from UART `busy`.
- `uart_tx_reg`  out  BIT_WIDTH  to UART `tx_reg`; held stable from the `send` pulse until the end of the transfer.
- `active`  out  1  high whenever the state is not IDLE.

## Operation
- All outputs are registered.
- Reset values:
  - `grant`, `done`, `err`, `uart_send` = 0.
  - `uart_tx_reg` = 0.
  - `active` = 0.
  - state = IDLE.
  - round-robin pointer `last` = NUM_REQ-1, so requester 0 has highest priority after reset.
- States: IDLE, WAIT_BUSY, WAIT_DONE.
- **IDLE**, when `req` ≠ 0 and `uart_busy` = 0:
  - Select the first set `req` bit, searching from index `last`+1 upward and wrapping modulo NUM_REQ.
  - On the next edge: `grant[sel]` ← 1, `uart_tx_reg` ← data of requester `sel`, `uart_send` ← 1, `last` ← `sel`, owner ← `sel`, timer ← 0, state ← WAIT_BUSY.
  - While `uart_busy` = 1, IDLE grants nothing.
- **WAIT_BUSY**:
  - `grant` and `uart_send` return to 0 after one cycle.
  - If `uart_busy` = 1, state ← WAIT_DONE.
  - Otherwise the timer increments. When timer = BUSY_TIMEOUT-1 with `uart_busy` still 0: `err[owner]` pulses and state ← IDLE.
- **WAIT_DONE**: when `uart_busy` = 0, `done[owner]` pulses and state ← IDLE.
- Requester contract:
  - Hold `req` and data stable until `grant`.
  - After `grant`, the requester may change data or drop `req`.
  - `req` still high in the cycle after `grant` is a new request.
  - Deasserting `req` before `grant` withdraws it without side effects.
- Fairness: a requester that has just been served is the lowest priority at the next arbitration. With all requests held, service order is 0,1,…,NUM_REQ-1,0,…
- `uart_tx_reg` keeps the last word after completion; it is not cleared.
- Reset mid-transfer: everything returns to reset values at the next edge. No `done` or `err` is issued for the aborted transfer.

## Timing
- Request-to-send latency: `req` sampled high in IDLE at cycle N gives `grant` and `uart_send` high in cycle N+1.
- Completion: `uart_busy` seen low in WAIT_DONE at cycle M gives `done` high in cycle M+1, with the state back in IDLE in that same cycle.
- Earliest next `grant` is cycle M+2, so there is one idle cycle between transfers.
- `uart_busy` already high in cycle N+1, at the `send` pulse: the transition to WAIT_DONE happens at the end of that cycle.
- `err` timing: `uart_busy` stuck low produces `err` in cycle N+1+BUSY_TIMEOUT.
- `grant`, `done` and `err` are never asserted together, and at most one bit of each is set.
- A `req` bit changing while the arbiter is in WAIT_BUSY or WAIT_DONE has no effect until IDLE.

## Test plan
- Single request: `req`=0001, data0=8'hA5. Required: `grant`=0001 and `uart_send` for 1 cycle, `uart_tx_reg`=A5. UART model raises busy after 1 cycle and holds it 10 cycles; `done`=0001 follows 1 cycle after busy falls.
- All requests held (NUM_REQ=4, data i=8'h10+i): `grant` sequence 0,1,2,3,0. Each `uart_tx_reg` value matches the granted requester, and there is exactly 1 idle cycle between `done` and the next `grant`.
- Timeout: the model never raises busy. Required: `err`=0001 exactly BUSY_TIMEOUT cycles after `uart_send`, no `done`, state returns to IDLE, and the next request is served normally.
- Busy at request: `uart_busy`=1 externally while `req`=0100. Required: no `grant` until 1 cycle after busy drops.
- Fairness and withdrawal: requester 1 is served; then `req`=0011. Required: the grant goes to 0 only after requester 1's `done`. Separately, pulse `req[2]` for 0 cycles of IDLE (dropped while the arbiter is busy) and confirm no `grant[2]` ever occurs.
- Reset mid-operation: assert `rst` during WAIT_DONE. Required: all outputs are 0 next cycle, no `done` is issued, and after reset `req`=1111 grants requester 0 first.
